// File: rtl/pipe_sequencer_if.sv
// pipe_sequencer_if
//   Groups the debug controls, the IF/ID instruction, the ROM address and the
//   status/performance outputs of the issue controller into one bundle.
//   master : board/ROM side (drives run, step, id_instr; observes the rest)
//   slave  : pipe_sequencer (consumes run, step, id_instr; drives the rest)
//   ADDR_W : PC / ROM address width (must match the sequencer's ADDR_W)
interface pipe_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              run;
  logic              step;
  logic [7:0]        id_instr;
  logic [ADDR_W-1:0] rom_addr;
  logic [ADDR_W-1:0] id_pc;
  logic              issue;
  logic              hazard;
  logic              busy;
  logic              halted;
  logic [15:0]       perf_cycles;
  logic [15:0]       perf_issued;
  logic [15:0]       perf_stalls;

  modport master (
    output run, step, id_instr,
    input  rom_addr, id_pc, issue, hazard, busy, halted,
    input  perf_cycles, perf_issued, perf_stalls
  );

  modport slave (
    input  run, step, id_instr,
    output rom_addr, id_pc, issue, hazard, busy, halted,
    output perf_cycles, perf_issued, perf_stalls
  );
endinterface

// File: rtl/pipe_sequencer.sv
// pipe_sequencer
//   Issue controller for the 5-stage 8-bit-instruction core. Owns the PC,
//   drives the instruction ROM address, detects RAW hazards of the ID
//   instruction against a 4-entry write scoreboard (ID/EX, EX/MEM, MEM/WB,
//   WB output) and sequences run / single-step / halt-drain.
//
//   Ports:
//     clk    : clock, all state on posedge
//     reset  : asynchronous, active-high; clears all state
//     bus    : pipe_sequencer_if.slave
//              run, step, id_instr in; rom_addr, id_pc, issue, hazard,
//              busy, halted, perf_cycles/issued/stalls out
//
//   Configuration macro: PIPE_SEQ_PERF_EN
//     defined   : saturating performance counters are built
//     undefined : counter logic absent, perf_* tied to 0
module pipe_sequencer #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = '1,
  parameter int                SB_DEPTH  = 4
) (
  input logic             clk,
  input logic             reset,
  pipe_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] dest;
  } sb_entry_t;

  state_t                   state_q, state_d;
  logic                     id_valid_q, id_valid_d;
  logic [ADDR_W-1:0]        id_pc_q, id_pc_d;
  sb_entry_t [SB_DEPTH-1:0] sb_q, sb_d;
  logic                     busy_q, busy_d;
  logic                     halted_q, halted_d;

  logic              instr_mode;
  logic [2:0]        opcode;
  logic [1:0]        dest;
  logic [1:0]        src1;
  logic              writes_dest;
  logic              reads_src1;
  logic              halt_in_id;
  logic              hazard_c;
  logic              issue_c;
  logic              sb_any;
  logic              sb_any_next;
  logic              at_last;
  logic [ADDR_W-1:0] rom_addr_c;

  assign instr_mode = bus.id_instr[7];
  assign opcode     = bus.id_instr[6:4];
  assign dest       = bus.id_instr[3:2];
  assign src1       = bus.id_instr[1:0];

  // Decode, hazard detection and the issue decision. src0 shares the dest
  // field, so every writing opcode also reads it; only ADD reads src1.
  always_comb begin
    writes_dest = (opcode != 3'b000);
    reads_src1  = (opcode == 3'b001);
    halt_in_id  = id_valid_q & instr_mode & (opcode == 3'b000);
    hazard_c    = 1'b0;
    sb_any      = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (sb_q[k].valid) begin
        sb_any = 1'b1;
        if ((writes_dest && sb_q[k].dest == dest) ||
            (reads_src1 && sb_q[k].dest == src1)) begin
          hazard_c = 1'b1;
        end
      end
    end
    hazard_c = hazard_c & id_valid_q;
    issue_c  = id_valid_q & ~hazard_c & ~halt_in_id &
               (((state_q == RUN) & bus.run) | (state_q == STEP));
    at_last  = (id_pc_q == LAST_ADDR);
    // The last legal PC never advances, so the program cannot wrap to 0.
    rom_addr_c = (issue_c && !at_last) ? id_pc_q + ADDR_W'(1) : id_pc_q;
  end

  // Next-state: scoreboard shift, PC follow, FSM and registered status.
  // A non-issuing cycle shifts in an invalid entry, which is the bubble.
  always_comb begin
    sb_d          = '0;
    sb_d[0].valid = issue_c & writes_dest;
    sb_d[0].dest  = dest;
    for (int k = 1; k < SB_DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    sb_any_next = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      sb_any_next = sb_any_next | sb_d[k].valid;
    end

    id_valid_d = 1'b1;
    id_pc_d    = rom_addr_c;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = RUN;
        end else if (bus.step) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else if (halt_in_id || (issue_c && at_last)) begin
          state_d = DRAIN;
        end
      end
      STEP: begin
        if (issue_c) begin
          state_d = at_last ? DRAIN : IDLE;
        end else if (halt_in_id) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!sb_any) begin
          state_d = HALTED;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == RUN) || (state_d == STEP) || (state_d == DRAIN) ||
               sb_any_next;
    halted_d = (state_d == HALTED);
  end

  // All sequencer state; reset must be shared with the rest of the core
  // because in-flight writes are forgotten here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      sb_q       <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      sb_q       <= sb_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.rom_addr = rom_addr_c;
  assign bus.id_pc    = id_pc_q;
  assign bus.issue    = issue_c;
  assign bus.hazard   = hazard_c;
  assign bus.busy     = busy_q;
  assign bus.halted   = halted_q;

`ifdef PIPE_SEQ_PERF_EN
  logic [15:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_issued_q, perf_issued_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  // Saturating counters: active cycles, issues, and stalls while issuing
  // was wanted (RUN or STEP).
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_issued_d = perf_issued_q;
    perf_stalls_d = perf_stalls_q;
    if (state_q != IDLE && state_q != HALTED && perf_cycles_q != 16'hFFFF) begin
      perf_cycles_d = perf_cycles_q + 16'd1;
    end
    if (issue_c && perf_issued_q != 16'hFFFF) begin
      perf_issued_d = perf_issued_q + 16'd1;
    end
    if (hazard_c && (state_q == RUN || state_q == STEP) &&
        perf_stalls_q != 16'hFFFF) begin
      perf_stalls_d = perf_stalls_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_issued_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_issued_q <= perf_issued_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_issued = perf_issued_q;
  assign bus.perf_stalls = perf_stalls_q;
`else
  assign bus.perf_cycles = '0;
  assign bus.perf_issued = '0;
  assign bus.perf_stalls = '0;
`endif

endmodule
